// File: rtl/fire_sequencer_pkg.sv
// Shared constants and encodings for the fire sequencer: board/turn defaults,
// cell status codes and the phase codes reported to the display logic.
package fire_sequencer_pkg;

  localparam int GRID_N_DEF    = 10;
  localparam int MAX_TURNS_DEF = 20;

  typedef enum logic [1:0] {
    CELL_UNTARGETED = 2'b00,
    CELL_MISS       = 2'b01,
    CELL_HIT        = 2'b10,
    CELL_SUNK       = 2'b11
  } cell_status_e;

  typedef enum logic [1:0] {
    PHASE_PLAY = 2'b00,
    PHASE_BUSY = 2'b01,
    PHASE_WIN  = 2'b10,
    PHASE_LOSE = 2'b11
  } phase_e;

endpackage

// File: rtl/fire_sequencer_if.sv
// Shot handshake between the fire sequencer (master) and the game logic (slave).
interface fire_sequencer_if;

  logic       fire_req;
  logic [3:0] fire_row;
  logic [3:0] fire_col;
  logic       fire_ack;

  modport master (output fire_req, fire_row, fire_col, input fire_ack);
  modport slave  (input fire_req, fire_row, fire_col, output fire_ack);

endinterface

// File: rtl/fire_sequencer_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, stable-level debounce and a one-cycle
// press pulse on each accepted 0->1 change of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_vld;
  logic             r_armed;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_done;

  // Until armed, the counter times a stable-low run instead, so a button held
  // through reset must be released before it can ever produce a press.
  assign w_differs = r_armed ? (r_sync2 != r_level) : (r_vld[1] & ~r_sync2);
  assign w_done    = w_differs && (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous and checked first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
      r_press <= 1'b0;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt <= '0;
        if (r_armed) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
        end else begin
          r_armed <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/fire_sequencer.sv
// Shot sequencer: latches the cursor on a debounced press, rejects bad targets,
// runs the fire_req/fire_ack handshake with timeout, and tracks turns and game end.
module fire_sequencer
  import fire_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_TURNS       = MAX_TURNS_DEF,
  parameter int GRID_N          = GRID_N_DEF,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         btn_c,
  input  logic [3:0]                   sprite_row,
  input  logic [3:0]                   sprite_col,
  input  logic [2*GRID_N*GRID_N-1:0]   cell_status_flat,
  input  logic [2:0]                   ships_remaining,
  fire_sequencer_if.master             fire_if,
  output logic [4:0]                   turns_left,
  output logic [1:0]                   phase,
  output logic                         input_lock
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_WIN    = 3'd4;
  localparam logic [2:0] S_LOSE   = 3'd5;

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [4:0]       GRID_LIM = 5'(GRID_N);

  logic [2:0]       r_state;
  logic [3:0]       r_fire_row;
  logic [3:0]       r_fire_col;
  logic [4:0]       r_turns;
  logic [TMO_W-1:0] r_tmo;

  logic             w_btn_level;
  logic             w_btn_press;
  logic             w_in_grid;
  logic [31:0]      w_bit_idx;
  cell_status_e     w_cell;
  logic             w_target_ok;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_c),
    .level  (w_btn_level),
    .press  (w_btn_press)
  );

  // The bounds test guards the cell lookup; an off-board index is never consulted.
  assign w_in_grid   = ({1'b0, r_fire_row} < GRID_LIM) && ({1'b0, r_fire_col} < GRID_LIM);
  assign w_bit_idx   = ((32'(r_fire_row) * 32'(GRID_N)) + 32'(r_fire_col)) << 1;
  assign w_cell      = cell_status_e'(2'(cell_status_flat >> w_bit_idx));
  assign w_target_ok = w_in_grid && (w_cell == CELL_UNTARGETED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fire_row <= 4'd0;
      r_fire_col <= 4'd0;
      r_turns    <= 5'(MAX_TURNS);
      r_tmo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_btn_press && w_btn_level) begin
            r_fire_row <= sprite_row;
            r_fire_col <= sprite_col;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_tmo   <= '0;
          r_state <= w_target_ok ? S_REQ : S_IDLE;
        end
        S_REQ: begin
          if (fire_if.fire_ack) begin
            r_state <= S_RESULT;
            if (r_turns != 5'd0) r_turns <= r_turns - 5'd1;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RESULT: begin
          if (ships_remaining == 3'd0)  r_state <= S_WIN;
          else if (r_turns == 5'd0)     r_state <= S_LOSE;
          else                          r_state <= S_IDLE;
        end
        S_WIN, S_LOSE: r_state <= r_state;
        default:       r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    phase = PHASE_BUSY;
    case (r_state)
      S_IDLE:  phase = PHASE_PLAY;
      S_WIN:   phase = PHASE_WIN;
      S_LOSE:  phase = PHASE_LOSE;
      default: phase = PHASE_BUSY;
    endcase
  end

  assign input_lock       = (r_state != S_IDLE);
  assign turns_left       = r_turns;
  assign fire_if.fire_req = (r_state == S_REQ);
  assign fire_if.fire_row = r_fire_row;
  assign fire_if.fire_col = r_fire_col;

endmodule

// File: tb/tb_fire_sequencer.sv
// Randomized self-checking bench for fire_sequencer against a shot-level model.
module tb_fire_sequencer;

  localparam int TB_DEBOUNCE = 4;
  localparam int TB_TURNS    = 2;
  localparam int TB_GRID     = 10;
  localparam int TB_TIMEOUT  = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         btn_c;
  logic [3:0]   sprite_row;
  logic [3:0]   sprite_col;
  logic [199:0] cell_status_flat;
  logic [2:0]   ships_remaining;
  logic [4:0]   turns_left;
  logic [1:0]   phase;
  logic         input_lock;

  fire_sequencer_if fif ();

  fire_sequencer #(
    .DEBOUNCE_CYCLES (TB_DEBOUNCE),
    .MAX_TURNS       (TB_TURNS),
    .GRID_N          (TB_GRID),
    .ACK_TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .btn_c            (btn_c),
    .sprite_row       (sprite_row),
    .sprite_col       (sprite_col),
    .cell_status_flat (cell_status_flat),
    .ships_remaining  (ships_remaining),
    .fire_if          (fif.master),
    .turns_left       (turns_left),
    .phase            (phase),
    .input_lock       (input_lock)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Observed activity, accumulated by the monitor and sampled as deltas.
  int         req_rises  = 0;
  int         hi_total   = 0;
  int         unstable   = 0;
  int         lock_total = 0;
  int         lock_rises = 0;
  logic       prev_req   = 1'b0;
  logic       prev_lock  = 1'b0;
  logic [3:0] cap_row    = 4'd0;
  logic [3:0] cap_col    = 4'd0;

  always @(negedge clk) begin
    if (fif.fire_req) begin
      hi_total <= hi_total + 1;
      if (!prev_req) begin
        req_rises <= req_rises + 1;
        cap_row   <= fif.fire_row;
        cap_col   <= fif.fire_col;
      end else if (fif.fire_row != cap_row || fif.fire_col != cap_col) begin
        unstable <= unstable + 1;
      end
    end
    if (input_lock) lock_total <= lock_total + 1;
    if (input_lock && !prev_lock) lock_rises <= lock_rises + 1;
    prev_req  <= fif.fire_req;
    prev_lock <= input_lock;
  end

  // Game-logic stand-in: acks after plan_d cycles of request, noise ack otherwise.
  int         plan_d     = 0;
  logic [2:0] plan_ships = 3'd3;

  initial begin
    int ack_cnt;
    ack_cnt         = 0;
    fif.fire_ack    = 1'b0;
    ships_remaining = 3'd3;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_cnt         = 0;
        fif.fire_ack    = 1'b0;
        ships_remaining = 3'd3;
      end else if (fif.fire_req) begin
        ack_cnt++;
        if (ack_cnt == plan_d + 1) begin
          fif.fire_ack    = 1'b1;
          ships_remaining = plan_ships;
        end else begin
          fif.fire_ack = 1'b0;
        end
      end else begin
        ack_cnt      = 0;
        fif.fire_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Shot-level reference state.
  int         m_turns;
  logic [1:0] m_phase;
  bit         m_over;

  task automatic model_reset();
    m_turns = TB_TURNS;
    m_phase = 2'b00;
    m_over  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_c = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    check("rst_turns", 32'(turns_left), 32'(TB_TURNS));
    check("rst_phase", 32'(phase), 32'd0);
  endtask

  task automatic attempt(input logic [3:0] row, input logic [3:0] col, input logic [1:0] st,
                         input int d, input logic [2:0] ships, input int nb);
    int  r0, h0, u0, l0, lr0;
    int  exp_hi, exp_lock;
    bit  over0, valid, acked, scrambled;
    sprite_row = row;
    sprite_col = col;
    for (int k = 0; k < TB_GRID * TB_GRID; k++) cell_status_flat[2*k +: 2] = 2'($urandom);
    if (row < TB_GRID && col < TB_GRID) cell_status_flat[2*(row*TB_GRID+col) +: 2] = st;
    plan_d     = d;
    plan_ships = ships;
    r0 = req_rises; h0 = hi_total; u0 = unstable; l0 = lock_total; lr0 = lock_rises;

    over0    = m_over;
    valid    = !m_over && row < TB_GRID && col < TB_GRID && st == 2'b00;
    acked    = valid && d < TB_TIMEOUT;
    exp_hi   = !valid ? 0 : (acked ? d + 1 : TB_TIMEOUT);
    exp_lock = !valid ? 1 : (acked ? exp_hi + 2 : exp_hi + 1);
    if (acked) begin
      if (m_turns > 0) m_turns--;
      if (ships == 3'd0) begin
        m_phase = 2'b10; m_over = 1'b1;
      end else if (m_turns == 0) begin
        m_phase = 2'b11; m_over = 1'b1;
      end
    end

    for (int i = 0; i < nb; i++) begin
      btn_c = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      btn_c = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    btn_c     = 1'b1;
    scrambled = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (input_lock && !scrambled) begin
        sprite_row = 4'($urandom);
        sprite_col = 4'($urandom);
        scrambled  = 1'b1;
      end
    end
    btn_c = 1'b0;
    repeat (14) @(negedge clk);

    check("req_pulses", 32'(req_rises - r0), valid ? 32'd1 : 32'd0);
    check("req_cycles", 32'(hi_total - h0), 32'(exp_hi));
    check("tgt_stable", 32'(unstable - u0), 32'd0);
    if (valid) begin
      check("fire_row", 32'(cap_row), 32'(row));
      check("fire_col", 32'(cap_col), 32'(col));
    end
    check("lock_entries", 32'(lock_rises - lr0), over0 ? 32'd0 : 32'd1);
    if (!m_over) check("lock_cycles", 32'(lock_total - l0), 32'(exp_lock));
    check("turns_left", 32'(turns_left), 32'(m_turns));
    check("phase", 32'(phase), 32'(m_phase));
    check("input_lock", 32'(input_lock), 32'(m_over));
    check("req_idle", 32'(fif.fire_req), 32'd0);
  endtask

  task automatic reset_mid_req();
    bit found;
    sprite_row       = 4'd1;
    sprite_col       = 4'd1;
    cell_status_flat = '0;
    plan_d           = 50;
    btn_c            = 1'b1;
    found            = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fif.fire_req) begin
        found = 1'b1;
        break;
      end
    end
    check("mr_req_seen", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mr_fire_req", 32'(fif.fire_req), 32'd0);
    check("mr_turns", 32'(turns_left), 32'(TB_TURNS));
    check("mr_phase", 32'(phase), 32'd0);
    check("mr_lock", 32'(input_lock), 32'd0);
    check("mr_row", 32'(fif.fire_row), 32'd0);
    btn_c = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int r0, lr0;
    logic [3:0] rr, cc;
    reset            = 1'b1;
    btn_c            = 1'b0;
    sprite_row       = 4'd0;
    sprite_col       = 4'd0;
    cell_status_flat = '0;
    repeat (3) @(negedge clk);
    check("por_turns", 32'(turns_left), 32'(TB_TURNS));
    check("por_phase", 32'(phase), 32'd0);
    check("por_lock", 32'(input_lock), 32'd0);
    check("por_req", 32'(fif.fire_req), 32'd0);
    check("por_row", 32'(fif.fire_row), 32'd0);
    check("por_col", 32'(fif.fire_col), 32'd0);

    // Button held across reset release must not fire.
    btn_c = 1'b1;
    repeat (2) @(negedge clk);
    r0 = req_rises; lr0 = lock_rises;
    reset = 1'b0;
    model_reset();
    repeat (15) @(negedge clk);
    check("held_no_req", 32'(req_rises - r0), 32'd0);
    check("held_no_lock", 32'(lock_rises - lr0), 32'd0);
    btn_c = 1'b0;
    repeat (12) @(negedge clk);

    attempt(4'd3, 4'd5, 2'b00, 2, 3'd3, 1);
    attempt(4'd4, 4'd4, 2'b01, 0, 3'd3, 0);
    attempt(4'd12, 4'd3, 2'b00, 0, 3'd3, 0);
    attempt(4'd6, 4'd7, 2'b00, 9, 3'd3, 2);
    attempt(4'd2, 4'd2, 2'b00, 5, 3'd3, 1);
    attempt(4'd1, 4'd1, 2'b00, 0, 3'd3, 1);

    do_reset();
    attempt(4'd0, 4'd0, 2'b00, 1, 3'd3, 0);
    reset_mid_req();
    attempt(4'd5, 4'd5, 2'b00, 0, 3'd2, 2);
    attempt(4'd9, 4'd9, 2'b00, 3, 3'd0, 1);
    attempt(4'd8, 4'd8, 2'b00, 0, 3'd0, 1);

    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int a = 0; a < 8; a++) begin
        rr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        cc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        attempt(rr, cc,
                ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                $urandom_range(0, 11),
                ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 3)),
                $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire_sequencer.md
FIRE_SEQUENCER -- requirements
Module: fire_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the stable-level cycles needed to accept a btn_c level change.
REQ-002 Parameter MAX_TURNS, default 20, SHALL set the turns_left reset value (max 31).
REQ-003 Parameter GRID_N, default 10, SHALL set the board dimension in cells.
REQ-004 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum REQ-state cycles spent waiting for fire_ack.
REQ-005 Ports: clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 btn_c  in  1  raw centre button; asynchronous and bouncing.
REQ-008 sprite_row, sprite_col  in  4 each  current cursor cell.
REQ-009 cell_status_flat  in  200  2 bits per cell; cell (r,c) at bits [2k+1:2k], k = r*GRID_N+c; 00 = untargeted.
REQ-010 ships_remaining  in  3  live count from game logic.
REQ-011 fire_ack  in  1  game logic has consumed the shot.
REQ-012 fire_req  out  1  shot request.
REQ-013 fire_row, fire_col  out  4 each  target latched for the shot.
REQ-014 turns_left  out  5  shots remaining.
REQ-015 phase  out  2  00 PLAY, 01 BUSY, 10 WIN, 11 LOSE.
REQ-016 input_lock  out  1  cursor movement SHALL be frozen while high.

Function
REQ-017 btn_c SHALL pass through a 2-FF synchronizer.
- The debounced level SHALL update only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any earlier reversion SHALL clear the counter.
REQ-018 A 0->1 change of the debounced level SHALL produce exactly one single-cycle press pulse.
REQ-019 FSM states SHALL be IDLE, CHECK, REQ, RESULT, WIN, LOSE.
REQ-020 IDLE + press: sprite_row/sprite_col SHALL be latched into fire_row/fire_col; next state CHECK.
REQ-021 A press in any state other than IDLE SHALL be discarded, not queued.
REQ-022 CHECK (1 cycle):
- Either coordinate >= GRID_N, or target cell status != 00 -> IDLE, turns_left unchanged.
- Otherwise -> REQ.
REQ-023 REQ: fire_req SHALL be 1, and fire_row/fire_col SHALL stay stable, until fire_ack is sampled high.
- Next cycle: fire_req = 0, turns_left decrements by 1, next state RESULT.
REQ-024 REQ timeout: if ACK_TIMEOUT cycles elapse without fire_ack -> IDLE, fire_req = 0, turns_left unchanged.
REQ-025 fire_ack outside REQ SHALL be ignored.
REQ-026 RESULT SHALL wait exactly 1 cycle, then evaluate in priority order:
- ships_remaining == 0 -> WIN;
- else turns_left == 0 -> LOSE;
- else IDLE.
REQ-027 A final-turn shot that sinks the last ship SHALL yield WIN.
REQ-028 WIN and LOSE SHALL be absorbing until reset.
REQ-029 turns_left SHALL saturate at 0 and never wrap.
REQ-030 phase decode: IDLE = 00; CHECK/REQ/RESULT = 01; WIN = 10; LOSE = 11.
REQ-031 input_lock SHALL be 1 in every state except IDLE.

Reset
REQ-032 Reset asserted, in any state including mid-REQ, SHALL immediately force:
- state IDLE;
- fire_req 0, fire_row 0, fire_col 0;
- turns_left MAX_TURNS;
- phase 00, input_lock 0;
- synchronizer, debounce and timeout counters 0.
REQ-033 After reset deasserts, a button already held SHALL NOT produce a press until it is released and re-pressed.

Structure
REQ-034 The shared package SHALL hold:
- GRID_N and MAX_TURNS defaults;
- 2-bit cell status encodings;
- the phase encodings.
REQ-035 Synchronizer, debounce and edge detect SHALL live in sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, btn_in, level, press).
REQ-036 FSM, target check, timeout counter and turns counter SHALL reside in fire_sequencer.

Verification (DEBOUNCE_CYCLES=4, MAX_TURNS=2, ACK_TIMEOUT=8 unless stated)
REQ-037 btn_c bounces 1-0-1 within 3 cycles, then holds 1 -> exactly one press; one fire_req at cursor (3,5); phase 01.
REQ-038 Cursor on a cell with status 01, press -> no fire_req; turns_left stays 2; back in IDLE after 2 cycles.
REQ-039 Cursor (2,2), press, fire_ack raised 5 cycles into REQ -> fire_req high exactly 6 cycles; turns_left 2->1; phase returns 00.
REQ-040 No fire_ack for 8 cycles -> fire_req drops; turns_left unchanged; IDLE.
REQ-041 Two accepted shots, ships_remaining=3 -> LOSE (11); further presses ignored.
- Repeat with ships_remaining driven to 0 on the second ack -> WIN (10).
REQ-042 Reset pulsed while fire_req = 1 -> fire_req 0 the same cycle; turns_left = 2; phase 00.
